// File: rtl/alu_pkg.sv
// Shared types for the ALU adder issue path: opcode encoding and adder flag bundle.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_CMP  = 2'd2,
        OP_PASS = 2'd3
    } alu_add_op_e;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic exception;
    } add_flags_t;

endpackage

// File: rtl/alu_stat_counter.sv
// ALU status: sticky overflow bit and saturating count of completed operations.
module alu_stat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 done_i,
    input  logic                 ovf_i,
    input  logic                 clr_i,
    output logic                 sticky_o,
    output logic [CNT_WIDTH-1:0] count_o
);

    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // A completion with overflow in the same cycle as a clear keeps the bit set.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clr_i) begin
            sticky_d = 1'b0;
        end
        if (done_i && ovf_i) begin
            sticky_d = 1'b1;
        end
        if (done_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign sticky_o = sticky_q;
    assign count_o  = count_q;

endmodule

// File: rtl/alu_adder_issue.sv
// Two-entry issue stage for the external combinational adder: operand register (S1),
// result register (S2), plus ALU status counters.
module alu_adder_issue
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = ALU_WIDTH,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_op,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic [WIDTH-1:0]     add_i_1,
    output logic [WIDTH-1:0]     add_i_2,
    output logic                 add_invert_i_2,
    input  logic [WIDTH-1:0]     add_o,
    input  logic                 add_overflow_flag,
    input  logic                 add_zero_flag,
    input  logic                 add_exception_flag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic                 out_zero,
    output logic                 out_overflow,
    output logic                 out_exception,
    output logic                 sticky_ovf,
    input  logic                 clr_sticky,
    output logic [CNT_WIDTH-1:0] op_count
);

    logic        s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    alu_add_op_e s1_op_q, s1_op_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_result_q, out_result_d;
    add_flags_t       out_flags_q, out_flags_d;

    logic s2_take;
    logic s1_adv;
    logic in_fire;
    logic s2_done;

    assign s2_take  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_take;
    assign in_ready = !s1_valid_q || s2_take;
    assign in_fire  = in_valid && in_ready;
    assign s2_done  = out_valid_q && out_ready;

    // Adder is driven straight from S1 so the inputs hold the last operands when idle.
    always_comb begin
        add_i_1        = s1_a_q;
        add_i_2        = s1_b_q;
        add_invert_i_2 = 1'b0;
        case (s1_op_q)
            OP_SUB, OP_CMP: add_invert_i_2 = 1'b1;
            OP_PASS:        add_i_2        = '0;
            default:        ;
        endcase
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_a_d     = in_a;
            s1_b_d     = in_b;
            s1_op_d    = alu_add_op_e'(in_op);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q && !out_ready;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        if (s1_adv) begin
            out_valid_d  = 1'b1;
            out_result_d = (s1_op_q == OP_CMP) ? '0 : add_o;
            out_flags_d  = '{zero:      add_zero_flag,
                             overflow:  add_overflow_flag,
                             exception: add_exception_flag};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_op_q      <= OP_ADD;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_a_q       <= s1_a_d;
            s1_b_q       <= s1_b_d;
            s1_op_q      <= s1_op_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_result    = out_result_q;
    assign out_zero      = out_flags_q.zero;
    assign out_overflow  = out_flags_q.overflow;
    assign out_exception = out_flags_q.exception;

    alu_stat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stat (
        .clk      (clk),
        .rst_n    (rst_n),
        .done_i   (s2_done),
        .ovf_i    (out_flags_q.overflow),
        .clr_i    (clr_sticky),
        .sticky_o (sticky_ovf),
        .count_o  (op_count)
    );

endmodule

// File: tb/tb_alu_adder_issue.sv
// Randomized and directed bench for alu_adder_issue with a stand-in adder and reference model.
module tb_alu_adder_issue;

    localparam int unsigned W    = 32;
    localparam int unsigned CW   = 4;
    localparam logic [1:0] T_ADD = 2'd0, T_SUB = 2'd1, T_CMP = 2'd2, T_PASS = 2'd3;
    localparam longint SMAX = 64'sh7FFFFFFF;
    localparam longint SMIN = -64'sh80000000;

    logic          clk, rst_n;
    logic          in_valid, in_ready;
    logic [1:0]    in_op;
    logic [W-1:0]  in_a, in_b;
    logic [W-1:0]  add_i_1, add_i_2, add_o;
    logic          add_invert_i_2, add_overflow_flag, add_zero_flag, add_exception_flag;
    logic          out_valid, out_ready;
    logic [W-1:0]  out_result;
    logic          out_zero, out_overflow, out_exception;
    logic          sticky_ovf, clr_sticky;
    logic [CW-1:0] op_count;

    int checks = 0;
    int errors = 0;

    alu_adder_issue #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .add_i_1(add_i_1), .add_i_2(add_i_2), .add_invert_i_2(add_invert_i_2),
        .add_o(add_o), .add_overflow_flag(add_overflow_flag), .add_zero_flag(add_zero_flag),
        .add_exception_flag(add_exception_flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_overflow(out_overflow), .out_exception(out_exception),
        .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky), .op_count(op_count)
    );

    // Stand-in adder: overflow is unsigned carry (borrow when inverting), exception is signed overflow.
    logic [W-1:0] b_eff;
    logic [W:0]   full;
    always_comb begin
        b_eff              = add_invert_i_2 ? ~add_i_2 : add_i_2;
        full               = {1'b0, add_i_1} + {1'b0, b_eff} + {{W{1'b0}}, add_invert_i_2};
        add_o              = full[W-1:0];
        add_zero_flag      = (full[W-1:0] == '0);
        add_overflow_flag  = full[W] ^ add_invert_i_2;
        add_exception_flag = (add_i_1[W-1] == b_eff[W-1]) && (full[W-1] != add_i_1[W-1]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ovf;
        logic        exc;
    } rec_t;

    function automatic rec_t ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        rec_t   r;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint sd;
        case (op)
            T_ADD: begin
                r.res = a + b;
                r.z   = ((ua + ub) % 64'h1_0000_0000) == 0;
                r.ovf = (ua + ub) > 64'hFFFF_FFFF;
                sd    = sa + sb;
                r.exc = (sd > SMAX) || (sd < SMIN);
            end
            T_SUB, T_CMP: begin
                r.res = (op == T_CMP) ? 32'd0 : a - b;
                r.z   = (a == b);
                r.ovf = (ua < ub);
                sd    = sa - sb;
                r.exc = (sd > SMAX) || (sd < SMIN);
            end
            default: begin
                r.res = a;
                r.z   = (a == 0);
                r.ovf = 1'b0;
                r.exc = 1'b0;
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    rec_t   m1, m2;
    logic   m1v = 1'b0, m2v = 1'b0, m_sticky = 1'b0;
    int     m_cnt = 0;
    logic   armed = 1'b0;
    logic   last_acc;

    // One clock: drive at posedge+1, check and advance model at negedge, return at next posedge+1.
    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rdy, input logic clr, input logic rst);
        logic exp_ready, compl, take, adv;
        in_valid = v; in_op = op; in_a = a; in_b = b;
        out_ready = rdy; clr_sticky = clr; rst_n = rst;
        #4;
        exp_ready = !m1v || !m2v || rdy;
        if (armed) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, m2v});
            if (m2v) begin
                check("out_result", out_result, m2.res);
                check("out_zero", {31'd0, out_zero}, {31'd0, m2.z});
                check("out_overflow", {31'd0, out_overflow}, {31'd0, m2.ovf});
                check("out_exception", {31'd0, out_exception}, {31'd0, m2.exc});
            end
            check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
            check("op_count", {28'd0, op_count}, m_cnt);
            check("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, m_sticky});
        end
        last_acc = 1'b0;
        if (!rst) begin
            m1v = 1'b0; m2v = 1'b0; m_cnt = 0; m_sticky = 1'b0; armed = 1'b1;
        end else begin
            compl = m2v && rdy;
            take  = !m2v || rdy;
            adv   = m1v && take;
            last_acc = v && exp_ready;
            if (compl && m2.ovf) m_sticky = 1'b1;
            else if (clr)        m_sticky = 1'b0;
            if (compl && m_cnt < (2 ** CW) - 1) m_cnt++;
            if (adv) begin
                m2 = m1; m2v = 1'b1;
            end else if (compl) begin
                m2v = 1'b0;
            end
            if (last_acc) begin
                m1 = ref_op(op, a, b); m1v = 1'b1;
            end else if (adv) begin
                m1v = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy, input logic clr);
        step(1'b0, T_ADD, 32'd0, 32'd0, rdy, clr, 1'b1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        in_valid = 0; in_op = 0; in_a = 0; in_b = 0;
        out_ready = 0; clr_sticky = 0; rst_n = 0;
        @(posedge clk);
        #1;
        step(0, T_ADD, 0, 0, 0, 0, 0);
        step(0, T_ADD, 0, 0, 0, 0, 0);

        // ADD 15 + 39
        step(1, T_ADD, 32'd15, 32'd39, 1, 0, 1);
        idle(1, 0);
        check("add_valid", {31'd0, out_valid}, 32'd1);
        check("add_result", out_result, 32'd54);
        check("add_zero", {31'd0, out_zero}, 32'd0);
        check("add_ovf", {31'd0, out_overflow}, 32'd0);
        idle(1, 0);
        check("add_count", {28'd0, op_count}, 32'd1);

        // SUB equal operands, then CMP with borrow
        step(1, T_SUB, 32'd272, 32'd272, 1, 0, 1);
        idle(1, 0);
        check("sub_result", out_result, 32'd0);
        check("sub_zero", {31'd0, out_zero}, 32'd1);
        idle(1, 0);
        step(1, T_CMP, 32'd210, 32'd230, 1, 0, 1);
        idle(1, 0);
        check("cmp_result", out_result, 32'd0);
        check("cmp_zero", {31'd0, out_zero}, 32'd0);
        check("cmp_ovf", {31'd0, out_overflow}, 32'd1);
        idle(1, 0);
        idle(1, 1);
        check("clr_alone", {31'd0, sticky_ovf}, 32'd0);

        // Overflow sets sticky; clear racing an overflow completion leaves it set
        step(1, T_ADD, 32'hFFFF_FFFE, 32'h0000_0002, 1, 0, 1);
        idle(1, 0);
        check("ovf_flag", {31'd0, out_overflow}, 32'd1);
        idle(1, 0);
        check("ovf_sticky", {31'd0, sticky_ovf}, 32'd1);
        step(1, T_ADD, 32'hFFFF_FFFE, 32'h0000_0002, 1, 0, 1);
        idle(1, 0);
        idle(1, 1);
        check("set_wins", {31'd0, sticky_ovf}, 32'd1);
        idle(1, 1);
        check("clr_after", {31'd0, sticky_ovf}, 32'd0);

        // Backpressure with three back-to-back ADDs
        step(1, T_ADD, 32'd1, 32'd2, 0, 0, 1);
        step(1, T_ADD, 32'd3, 32'd4, 0, 0, 1);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_first", out_result, 32'd3);
        for (int unsigned i = 0; i < 3; i++) step(1, T_ADD, 32'd5, 32'd6, 0, 0, 1);
        check("bp_hold", out_result, 32'd3);
        begin
            int unsigned n = 0;
            do begin
                step(1, T_ADD, 32'd5, 32'd6, 1, 0, 1);
                n++;
            end while (!last_acc && n < 10);
            check("bp_accept", {31'd0, last_acc}, 32'd1);
        end
        check("bp_second", out_result, 32'd7);
        idle(1, 0);
        check("bp_third", out_result, 32'd11);
        idle(1, 0);
        idle(1, 0);

        // Reset with both stages full and sticky set
        step(1, T_ADD, 32'hFFFF_FFFF, 32'd1, 0, 0, 1);
        step(1, T_ADD, 32'd9, 32'd10, 0, 0, 1);
        idle(1, 0);
        step(1, T_ADD, 32'd11, 32'd12, 0, 0, 1);
        check("pre_rst_sticky", {31'd0, sticky_ovf}, 32'd1);
        step(0, T_ADD, 0, 0, 0, 0, 0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_count", {28'd0, op_count}, 32'd0);
        check("rst_sticky", {31'd0, sticky_ovf}, 32'd0);

        // Random traffic
        for (int unsigned i = 0; i < 600; i++) begin
            step($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), pick(), pick(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 15) == 0,
                 !($urandom_range(0, 199) == 0));
        end

        // Counter saturation
        step(0, T_ADD, 0, 0, 0, 0, 0);
        for (int unsigned i = 0; i < 17; i++) step(1, T_PASS, i, 32'd0, 1, 0, 1);
        idle(1, 0);
        idle(1, 0);
        idle(1, 0);
        check("sat_count", {28'd0, op_count}, 32'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
